uart_rx: RTL and testbench

Serial UART receiver and counterpart of the UART transmitter in the same codebase. It oversamples `RX_IN` with a runtime prescale, frames start, data (LSB first), optional parity and stop bits, and presents the parallel word with a one-cycle valid pulse. It sits between the serial pin (already synchronised upstream) and the system-side consumer, and shares the frame format and parity convention of the TX.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 95 +++++++++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_pkg                                                      |
// | Purpose  : Shared types and constants for the UART receiver (and the     |
// |            matching transmitter): FSM state encoding, parity-type codes, |
// |            and the width of the runtime prescale field.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package uart_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

  // Parity type select codes (PAR_TYP input)
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of the clocks-per-bit prescale field
  localparam int PRESCALE_W = 6;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_sampler                                               |
// | Purpose  : Per-bit timing for the UART receiver. Counts oversampling     |
// |            clocks inside a bit, captures the line value and produces a   |
// |            decision strobe plus an end-of-bit strobe.                    |
// | Macro    : UART_RX_MAJORITY_VOTE_EN - when defined, the bit value is the |
// |            2-of-3 vote of samples at Prescale/2-1, Prescale/2 and        |
// |            Prescale/2+1; otherwise the single sample at Prescale/2.      |
// | Ports    : clk_i        clock                                            |
// |            rst_ni       asynchronous active-low reset                    |
// |            rx_i         serial line (already synchronised)               |
// |            run_i        1 = keep counting, 0 = hold counter at zero      |
// |            prescale_i   clocks per bit (latched by the FSM)              |
// |            bit_o        decided bit value, valid when decide_o = 1       |
// |            decide_o     bit decision point (edge_cnt = Prescale/2+1)     |
// |            bit_end_o    last clock of the bit (edge_cnt = Prescale-1)    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  input  logic                  run_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  bit_o,
  output logic                  decide_o,
  output logic                  bit_end_o
);

  localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] edge_cnt_q;
  logic [PRESCALE_W-1:0] edge_cnt_d;
  logic [PRESCALE_W-1:0] half;

  assign half      = prescale_i >> 1;
  assign bit_end_o = (edge_cnt_q == (prescale_i - CNT_ONE));
  // The decision point sits one clock after the centre so that the
  // majority build can use the live line as its third sample.
  assign decide_o  = (edge_cnt_q == (half + CNT_ONE));

  always_comb begin
    edge_cnt_d = '0;
    if (run_i && !bit_end_o) begin
      edge_cnt_d = edge_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic s_lo_q;
  logic s_mid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_lo_q  <= 1'b1;
      s_mid_q <= 1'b1;
    end else begin
      if (edge_cnt_q == (half - CNT_ONE)) begin
        s_lo_q <= rx_i;
      end
      if (edge_cnt_q == half) begin
        s_mid_q <= rx_i;
      end
    end
  end

  // Third sample is the line itself at the decision clock.
  assign bit_o = (s_lo_q & s_mid_q) | (s_lo_q & rx_i) | (s_mid_q & rx_i);
`else
  logic s_mid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_mid_q <= 1'b1;
    end else if (edge_cnt_q == half) begin
      s_mid_q <= rx_i;
    end
  end

  assign bit_o = s_mid_q;
`endif

endmodule : uart_rx_sampler
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx                                                       |
// | Purpose  : Oversampling UART receiver. Frames start, DATA_WIDTH data     |
// |            bits (LSB first), optional parity and one stop bit, and       |
// |            reports each frame with a single one-cycle pulse.             |
// | Macro    : UART_RX_MAJORITY_VOTE_EN - selects 2-of-3 majority sampling   |
// |            in uart_rx_sampler (latency is unchanged).                    |
// | Ports    : CLK         oversampling clock (Prescale x bit rate)          |
// |            RST         asynchronous active-low reset                     |
// |            RX_IN       serial line, idle high                            |
// |            Prescale    clocks per bit, even, 4..32                       |
// |            PAR_EN      1 = parity bit follows the data                   |
// |            PAR_TYP     0 = even parity, 1 = odd parity                   |
// |            P_DATA      last correctly received word                      |
// |            Data_Valid  one-cycle pulse when P_DATA is updated            |
// |            PAR_ERR     one-cycle pulse on parity mismatch                |
// |            STP_ERR     one-cycle pulse when stop bit is 0                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int              BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0]  BIT_ONE  = BCW'(1);

  uart_rx_state_t          state_q;
  logic [BCW-1:0]          bit_cnt_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_mis_q;
  logic [PRESCALE_W-1:0]   prescale_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic [DATA_WIDTH-1:0]   p_data_q;
  logic                    valid_q;
  logic                    par_err_q;
  logic                    stp_err_q;

  logic                    rx_bit;
  logic                    decide;
  logic                    bit_end;
  logic                    frame_end;
  logic                    run;
  logic                    par_exp;

  // Frame ends at the decision point of a glitchy start bit or of the stop
  // bit. Leaving STOP half a bit early lets a back-to-back start edge be
  // seen on time even when the sender's bit clock runs slightly fast.
  assign frame_end = decide && (((state_q == START) && rx_bit) || (state_q == STOP));
  assign run       = (state_q == IDLE) ? ~RX_IN : ~frame_end;
  assign par_exp   = (par_typ_q == PAR_EVEN) ? ^shift_q : ~^shift_q;

  uart_rx_sampler u_sampler (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .rx_i       (RX_IN),
    .run_i      (run),
    .prescale_i (prescale_q),
    .bit_o      (rx_bit),
    .decide_o   (decide),
    .bit_end_o  (bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_mis_q  <= 1'b0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Configuration is tracked while idle, so the value present on
          // the start-edge clock is the one used for the whole frame.
          prescale_q <= Prescale;
          par_en_q   <= PAR_EN;
          par_typ_q  <= PAR_TYP;
          bit_cnt_q  <= '0;
          par_mis_q  <= 1'b0;
          if (!RX_IN) begin
            state_q <= START;
          end
        end
        START: begin
          if (decide && rx_bit) begin
            state_q <= IDLE;
          end else if (bit_end) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (decide) begin
            shift_q <= DATA_WIDTH'({rx_bit, shift_q} >> 1);
          end
          if (bit_end) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_ONE;
            end
          end
        end
        PARITY: begin
          if (decide) begin
            par_mis_q <= (rx_bit != par_exp);
          end
          if (bit_end) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            if (!rx_bit) begin
              stp_err_q <= 1'b1;
            end else if (par_mis_q) begin
              par_err_q <= 1'b1;
            end else begin
              valid_q  <= 1'b1;
              p_data_q <= shift_q;
            end
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx                                                    |
// | Purpose  : Self-checking bench for uart_rx. Frames are built from the    |
// |            data word and format; an event queue predicts each outcome   |
// |            pulse and its clock, and every cycle the outputs are compared |
// |            with that prediction. Literal checks pin key results.         |
// | Macro    : UART_RX_MAJORITY_VOTE_EN - adds the centre-glitch frame.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx;

  localparam int DW      = 8;
  localparam int K_VALID = 0;
  localparam int K_PAR   = 1;
  localparam int K_STP   = 2;

  typedef struct {
    int           at;
    int           kind;
    logic [DW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic [5:0]    presc;
  logic          pe;
  logic          pt;
  logic [DW-1:0] p_data;
  logic          dv;
  logic          perr;
  logic          serr;

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX_IN      (rx),
    .Prescale   (presc),
    .PAR_EN     (pe),
    .PAR_TYP    (pt),
    .P_DATA     (p_data),
    .Data_Valid (dv),
    .PAR_ERR    (perr),
    .STP_ERR    (serr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t           exp_q[$];
  int            vectors     = 0;
  int            errors      = 0;
  logic [DW-1:0] model_pdata = '0;
  int            last_dv     = -1;
  int            prev_dv     = -1;
  int            n_perr      = 0;
  int            n_serr      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the predicted event stream.
  task automatic monitor();
    forever begin
      logic edv;
      logic epe;
      logic ese;
      @(negedge clk);
      edv = 1'b0;
      epe = 1'b0;
      ese = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        case (exp_q[0].kind)
          K_VALID: begin edv = 1'b1; model_pdata = exp_q[0].data; end
          K_PAR:   epe = 1'b1;
          default: ese = 1'b1;
        endcase
        void'(exp_q.pop_front());
      end
      vectors++;
      if ({dv, perr, serr, p_data} !== {edv, epe, ese, model_pdata}) begin
        errors++;
        $display("FAIL outputs@%0d: got dv=%b perr=%b serr=%b pdata=%h, expected dv=%b perr=%b serr=%b pdata=%h",
                 cyc, dv, perr, serr, p_data, edv, epe, ese, model_pdata);
      end
      if (dv === 1'b1) begin
        prev_dv = last_dv;
        last_dv = cyc;
      end
      if (perr === 1'b1) n_perr++;
      if (serr === 1'b1) n_serr++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Drives one complete frame; t0 is the clock on which the start bit is
  // first sampled. glitch_off inverts the line for one clock at that offset.
  task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pen,
                            input logic ptyp, input logic par_flip, input logic stop_v,
                            input int glitch_off, output int t0);
    logic [15:0] bits;
    int          nb;
    ev_t         ev;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1 + i] = d[i];
    nb = 1 + DW;
    if (pen) begin
      bits[nb] = (^d) ^ ptyp ^ par_flip;
      nb++;
    end
    bits[nb] = stop_v;
    nb++;
    @(negedge clk);
    presc = p[5:0];
    pe    = pen;
    pt    = ptyp;
    t0    = cyc + 1;
    ev.at   = t0 + (1 + DW + (pen ? 1 : 0)) * p + p / 2 + 1;
    ev.data = d;
    if (!stop_v)               ev.kind = K_STP;
    else if (pen && par_flip)  ev.kind = K_PAR;
    else                       ev.kind = K_VALID;
    exp_q.push_back(ev);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < p; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        rx = bits[b] ^ ((b * p + c) == glitch_off);
        if (b == 0 && c == 1) begin
          // Mid-frame config changes must be ignored.
          presc = (p == 8) ? 6'd16 : 6'd8;
          pe    = ~pen;
          pt    = ~ptyp;
        end
      end
    end
  endtask

  initial begin
    int t0;
    int dummy;
    rst_n = 1'b0;
    rx    = 1'b1;
    presc = 6'd8;
    pe    = 1'b0;
    pt    = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_pdata", 32'(p_data), 32'h0);
    check("reset_flags", 32'({dv, perr, serr}), 32'h0);
    check("reset_state", 32'(dut.state_q), 32'(uart_pkg::IDLE));
    rst_n = 1'b1;
    idle(4);

    // 8'hA5, Prescale 8, no parity: 77-clock latency
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(8);
    check("latency_77", 32'(last_dv - t0), 32'd77);
    check("pdata_A5", 32'(p_data), 32'hA5);

    // Even parity, Prescale 16: good then bad parity
    send_frame(8'h03, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(16);
    check("pdata_03", 32'(p_data), 32'h03);
    send_frame(8'h03, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, t0);
    idle(16);
    check("par_err_count", 32'(n_perr), 32'd1);
    check("pdata_hold_03", 32'(p_data), 32'h03);

    // Odd parity, bad parity and bad stop: stop error wins
    send_frame(8'h5A, 8, 1'b1, 1'b1, 1'b1, 1'b0, -1, t0);
    idle(8);
    check("stp_err_count", 32'(n_serr), 32'd1);
    check("par_err_unchanged", 32'(n_perr), 32'd1);
    check("pdata_hold_5A", 32'(p_data), 32'h03);

    // Start glitch: two clocks low
    @(negedge clk);
    presc = 6'd8;
    pe    = 1'b0;
    rx    = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    idle(8);
    check("glitch_idle", 32'(dut.state_q), 32'(uart_pkg::IDLE));
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(8);
    check("pdata_3C", 32'(p_data), 32'h3C);

    // Back-to-back at Prescale 32
    send_frame(8'h11, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, dummy);
    send_frame(8'hEE, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(32);
    check("b2b_spacing", 32'(last_dv - prev_dv), 32'd320);
    check("pdata_EE", 32'(p_data), 32'hEE);

    // Reset in the middle of DATA
    @(negedge clk);
    presc = 6'd8;
    pe    = 1'b0;
    rx    = 1'b0;
    repeat (7) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      repeat (8) begin
        @(negedge clk);
        rx = (b != 0);
      end
    end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_pdata = '0;
    #1;
    check("midrst_pdata", 32'(p_data), 32'h0);
    check("midrst_flags", 32'({dv, perr, serr}), 32'h0);
    check("midrst_state", 32'(dut.state_q), 32'(uart_pkg::IDLE));
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(8);
    check("pdata_7E", 32'(p_data), 32'h7E);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-clock inverted glitch on the centre sample of D0
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8 + 4, t0);
    idle(8);
    check("majority_01", 32'(p_data), 32'h01);
`endif

    idle(4);
    check("events_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
